// File: rtl/id_imm_gen_pipe_pkg.sv
// imm_gen_pkg: immediate type codes and beat record shared by the immediate generator.
// Define IMM_GEN_RVC_EN to widen the type field to 4 bits and add the RV32C immediate codes.
package imm_gen_pkg;
`ifdef IMM_GEN_RVC_EN
  localparam int IMM_TYPE_W = 4;
`else
  localparam int IMM_TYPE_W = 3;
`endif
  localparam int XLEN = 32;
  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_I = 0, IMM_S = 1, IMM_B = 2, IMM_U = 3, IMM_J = 4, IMM_CSR = 5, IMM_SH = 6, IMM_ILL = 7
`ifdef IMM_GEN_RVC_EN
    , IMM_CI = 8, IMM_CIW = 9, IMM_CLW = 10, IMM_CSS = 11, IMM_CB = 12, IMM_CJ = 13,
    IMM_ILL14 = 14, IMM_ILL15 = 15
`endif
  } imm_type_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } imm_beat_t;
endpackage

// File: rtl/id_imm_gen_pipe_if.sv
// id_imm_gen_pipe_if: upstream/downstream valid-ready bus of the immediate generator.
// Upstream: flush, in_valid, in_ready, in_imm_type (TW bits per lane), in_instr (32 bits per lane).
// Downstream: out_valid, out_ready, out_imm (XLEN bits per lane), out_illegal (1 bit per lane).
// slave is the generator's view, master the surrounding pipeline's view.
interface id_imm_gen_pipe_if #(
  parameter int LANES = 1,
  parameter int XLEN  = 32,
  parameter int TW    = imm_gen_pkg::IMM_TYPE_W
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [TW*LANES-1:0]   in_imm_type;
  logic [32*LANES-1:0]   in_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN*LANES-1:0] out_imm;
  logic [LANES-1:0]      out_illegal;
  modport master (
    output flush, in_valid, in_imm_type, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_imm_type, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_illegal
  );
endinterface

// File: rtl/id_imm_gen_pipe_lane.sv
// imm_decode_lane: combinational immediate decode for one instruction lane.
// Ports: i_type (type code), i_instr (instruction word; RVC forms use [15:0]),
// o_imm (XLEN-bit extended immediate), o_illegal (type code not recognised).
// With IMM_GEN_RVC_EN defined, codes 8-13 decode RV32C immediates.
module imm_decode_lane #(
  parameter int XLEN = 32
) (
  input  logic [imm_gen_pkg::IMM_TYPE_W-1:0] i_type,
  input  logic [31:0]                        i_instr,
  output logic [XLEN-1:0]                    o_imm,
  output logic                               o_illegal
);
  import imm_gen_pkg::*;
  // Opcode bits feed no 32-bit immediate; RVC only uses some of them.
  logic w_unused;
  assign w_unused = ^i_instr[6:0];
  always_comb begin
    o_imm = '0;
    o_illegal = 1'b0;
    case (imm_type_e'(i_type))
      IMM_I:   o_imm = XLEN'($signed(i_instr[31:20]));
      IMM_S:   o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      IMM_B:   o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
      IMM_U:   o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      IMM_J:   o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
      IMM_CSR: o_imm = XLEN'(i_instr[19:15]);
      IMM_SH:  o_imm = (XLEN == 64) ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);
`ifdef IMM_GEN_RVC_EN
      IMM_CI:  o_imm = XLEN'($signed({i_instr[12], i_instr[6:2]}));
      IMM_CIW: o_imm = XLEN'({i_instr[10:7], i_instr[12:11], i_instr[5], i_instr[6], 2'b0});
      IMM_CLW: o_imm = XLEN'({i_instr[5], i_instr[12:10], i_instr[6], 2'b0});
      IMM_CSS: o_imm = XLEN'({i_instr[8:7], i_instr[12:9], 2'b0});
      IMM_CB:  o_imm = XLEN'($signed({i_instr[12], i_instr[6:5], i_instr[2], i_instr[11:10], i_instr[4:3], 1'b0}));
      IMM_CJ:  o_imm = XLEN'($signed({i_instr[12], i_instr[8], i_instr[10:9], i_instr[6], i_instr[7],
                                      i_instr[2], i_instr[11], i_instr[5:3], 1'b0}));
`endif
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_imm_gen_pipe.sv
// id_imm_gen_pipe: registered multi-lane immediate generator with a 2-entry skid buffer.
// Ports: clk, rst (sync, active high), bus (id_imm_gen_pipe_if.slave: flush, in_*/out_* handshakes).
// Define IMM_GEN_RVC_EN for 4-bit type codes with RV32C immediates.
module id_imm_gen_pipe #(
  parameter int LANES = 1,
  parameter int XLEN  = 32
) (
  input logic             clk,
  input logic             rst,
  id_imm_gen_pipe_if.slave bus
);
  import imm_gen_pkg::*;
  typedef struct packed {
    logic                  valid;
    logic [LANES*XLEN-1:0] imm;
    logic [LANES-1:0]      illegal;
  } beat_t;
  beat_t r_m, r_k, w_beat;
  logic [LANES*XLEN-1:0] w_imm;
  logic [LANES-1:0] w_ill;
  logic w_acc, w_xfer;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .i_type   (bus.in_imm_type[i*IMM_TYPE_W +: IMM_TYPE_W]),
      .i_instr  (bus.in_instr[i*32 +: 32]),
      .o_imm    (w_imm[i*XLEN +: XLEN]),
      .o_illegal(w_ill[i])
    );
  end
  assign w_beat = '{valid: 1'b1, imm: w_imm, illegal: w_ill};
  // K is only ever filled while M is full, so a full K means both are full.
  assign w_acc  = bus.in_valid && !r_k.valid;
  assign w_xfer = r_m.valid && bus.out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      r_m <= '0;
      r_k <= '0;
    end else if (bus.flush) begin
      r_m.valid <= 1'b0;
      r_k.valid <= 1'b0;
    end else if (w_acc && (!r_m.valid || w_xfer))
      r_m <= w_beat;
    else if (w_acc)
      r_k <= w_beat;
    else if (w_xfer) begin
      if (r_k.valid) r_m <= r_k;
      else r_m.valid <= 1'b0;
      r_k.valid <= 1'b0;
    end
  assign bus.in_ready    = !r_k.valid;
  assign bus.out_valid   = r_m.valid;
  assign bus.out_imm     = r_m.imm;
  assign bus.out_illegal = r_m.illegal;
endmodule
